// File: rtl/count_seq_checker_pkg.sv
// Shared definitions for the count sequence checker and its companion counter.
package count_seq_checker_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Successor in the 0..max_count wrap-around sequence, 8-bit arithmetic.
    // Both ends of the link use this so they agree on where the wrap happens.
    function automatic logic [COUNT_W-1:0] succ(input logic [COUNT_W-1:0] v,
                                                input logic [COUNT_W-1:0] max_count);
        if (v == max_count) begin
            return '0;
        end
        return v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear and an increment in
// the same cycle leave the counter at one.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         slowclk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Clear takes priority, then the increment is applied; never wraps past all-ones.
    always_ff @(posedge slowclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// Receive-side checker for the mod-(MAX_COUNT+1) count stream: hunts for a
// plausible value, confirms LOCK_COUNT consecutive correct samples, then
// flags every break in the sequence and keeps a saturating error tally.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int MAX_COUNT  = 9,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic               slowclk,
    input  logic               rst_n,
    input  logic               sample_en,
    input  logic [7:0]         seq_in,
    input  logic               clear_err,
    output logic               locked,
    output logic               err_pulse,
    output logic               wrap_pulse,
    output logic [ERR_W-1:0]   err_count,
    output logic [7:0]         expected
);

    localparam logic [7:0] MAX_V       = 8'(MAX_COUNT);
    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    chk_state_t state;
    logic [3:0] match_cnt;
    logic [3:0] match_next;
    logic       in_range;
    logic       hit;
    logic [7:0] next_expected;
    logic       err_inc;

    assign in_range      = (seq_in <= MAX_V);
    assign hit           = (seq_in == expected);
    assign next_expected = succ(seq_in, MAX_V);
    assign match_next    = match_cnt + 4'd1;

    // An error is any enabled sample that breaks the sequence while locked.
    assign err_inc = sample_en && (state == LOCKED) && !hit;

    // Lock FSM with registered status outputs; pulses default low every cycle.
    always_ff @(posedge slowclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            match_cnt  <= '0;
            expected   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (sample_en) begin
                case (state)
                    HUNT: begin
                        if (in_range) begin
                            expected  <= next_expected;
                            match_cnt <= 4'd1;
                            state     <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (hit) begin
                            expected  <= next_expected;
                            match_cnt <= match_next;
                            if (match_next == LOCK_TARGET) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (in_range) begin
                            expected  <= next_expected;
                            match_cnt <= 4'd1;
                        end else begin
                            match_cnt <= '0;
                            state     <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            expected   <= next_expected;
                            wrap_pulse <= (seq_in == MAX_V);
                        end else begin
                            err_pulse <= 1'b1;
                            locked    <= 1'b0;
                            if (in_range) begin
                                expected  <= next_expected;
                                match_cnt <= 4'd1;
                                state     <= SYNC;
                            end else begin
                                match_cnt <= '0;
                                state     <= HUNT;
                            end
                        end
                    end
                    default: begin
                        match_cnt <= '0;
                        locked    <= 1'b0;
                        state     <= HUNT;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_counter (
        .slowclk (slowclk),
        .rst_n   (rst_n),
        .inc     (err_inc),
        .clr     (clear_err),
        .cnt     (err_count)
    );

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive-side companion to the mod-10 free-running counter.
- Samples the 8-bit count stream on each enabled slowclk edge and locks onto the 0..MAX_COUNT wrap-around sequence.
- Flags every sequence break and keeps a saturating error tally.
- Sits on the far end of the counter's sw_out bus, e.g. on a second board or a loopback header; status drives LEDs.

Parameters:
- MAX_COUNT, 9: terminal value of the checked sequence; successor of MAX_COUNT is 0.
- LOCK_COUNT, 3: consecutive correct samples (including the seed) needed to declare lock; legal range 2..15.
- ERR_W, 8: width of the error counter.

Ports:
- slowclk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sample_en  input  1  qualifies seq_in this cycle; when low, nothing changes.
- seq_in  input  8  received count value.
- clear_err  input  1  synchronous clear of err_count.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse per detected break while locked.
- wrap_pulse  output  1  one-cycle pulse when a locked, correct sample equals MAX_COUNT.
- err_count  output  ERR_W  saturating count of err_pulse events.
- expected  output  8  value the checker predicts for the next enabled sample.

Behaviour:
- Reset (rst_n low, async): FSM state = HUNT, match_cnt = 0, expected = 0. All outputs are 0.
- All outputs are registered. The response to a sample appears on the edge that samples it, so it is visible in the following cycle.
- When sample_en = 0, all state holds and both pulses are 0. Pulses are only ever high for one cycle.
- succ(v) = 0 if v == MAX_COUNT, else v + 1. The arithmetic is 8-bit.
- A sample is "in range" when seq_in <= MAX_COUNT.
- HUNT:
  - In-range sample: expected <= succ(seq_in), match_cnt <= 1, go to SYNC.
  - Out-of-range sample: stay in HUNT.
  - No err_pulse is raised in HUNT.
- SYNC:
  - seq_in == expected: expected <= succ(seq_in) and match_cnt increments. When the new match_cnt == LOCK_COUNT, go to LOCKED and set locked = 1 on that edge.
  - Mismatch and in range: reseed with expected <= succ(seq_in), match_cnt <= 1, stay in SYNC.
  - Mismatch and out of range: go to HUNT, match_cnt <= 0.
  - No err_pulse is raised in SYNC.
- LOCKED:
  - seq_in == expected: expected <= succ(seq_in). wrap_pulse = 1 if seq_in == MAX_COUNT.
  - Mismatch (including out of range): err_pulse = 1, err_count increments, locked <= 0.
    - If seq_in is in range, reseed into SYNC with match_cnt = 1.
    - Otherwise go to HUNT.
- err_count saturates at all-ones and never wraps.
- clear_err sets err_count to 0. If an error occurs in the same cycle, err_count = 1 (clear first, then increment). err_pulse is unaffected by clear_err.
- A reset asserted mid-lock drops locked immediately (async). err_count returns to 0.
- The expected output in HUNT is don't-care for checking but holds its last value; after reset it is 0.

Decomposition:
- Shared package holds:
  - FSM state encoding: HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2.
  - The succ() function, parameterised by MAX_COUNT, shared with the counter so both ends agree on wrap.
- One natural sub-module: sat_counter (ERR_W wide, inc/clr inputs, clear-then-increment priority).
- The FSM stays in the top module.

Test Plan:
- Reset then seq 0,1,2,3…9,0 with sample_en = 1 -> locked rises after the sample of 2; wrap_pulse once at 9; err_count = 0; expected = 1 after 0.
- Locked, inject 5 where 4 is expected -> err_pulse 1 cycle, err_count = 1, locked = 0, state SYNC with expected = 6; then 6,7 -> relock after 7.
- Locked, inject 8'd200 -> err_pulse, err_count + 1, state HUNT; locked stays 0 until three good samples arrive.
- sample_en toggling 1,0,0,1 with seq 3,X,X,4 (X = garbage) -> no errors; the X values are ignored.
- Force 300 errors with ERR_W = 8 -> err_count stops at 255. clear_err together with an error -> err_count = 1.
- Assert rst_n low mid-stream while locked -> locked, err_count and pulses drop to 0 without a clock edge; after release, relock from scratch.
